// File: rtl/stp_fsm_param.sv
// Store-polynomial controller: loads N coefficients into slot A of a multi-slot
// coefficient memory and serves a registered, validity-gated read port.
module stp_fsm_param #(
  parameter int unsigned COEFF_W = 16,
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned N_W     = 5,
  parameter int unsigned MAX_N   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_stp,
  input  logic [ADDR_W-1:0]        A,
  input  logic [N_W-1:0]           N,
  input  logic                     en_mode_wr_coeff,
  input  logic [COEFF_W-1:0]       c,
  output logic                     en_rd_data,
  output logic                     done_stp,
  output logic [1:0]               status,
  output logic [(2**ADDR_W)-1:0]   slot_valid,
  input  logic [ADDR_W-1:0]        rd_slot,
  input  logic [N_W-1:0]           rd_idx,
  output logic [COEFF_W-1:0]       rd_coeff,
  output logic [N_W-1:0]           rd_n
);

  localparam int unsigned SLOTS  = 2**ADDR_W;
  localparam int unsigned MEM_D  = SLOTS * MAX_N;
  localparam int unsigned MEM_AW = (MEM_D > 1) ? $clog2(MEM_D) : 1;

  typedef enum logic [1:0] {IDLE, CHECK, GET, DONE} state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   a_q;
  logic [N_W-1:0]      n_q;
  logic [N_W-1:0]      idx;
  logic [1:0]          status_d;
  logic                latch_cmd;
  logic                clr_valid;
  logic                commit;
  logic                beat_c;
  logic [MEM_AW-1:0]   waddr;
  logic [MEM_AW-1:0]   raddr;

  logic [COEFF_W-1:0]  mem [MEM_D];
  logic [N_W-1:0]      len [SLOTS];

  assign beat_c = en_rd_data && en_mode_wr_coeff;
  assign waddr  = MEM_AW'(a_q) * MEM_AW'(MAX_N) + MEM_AW'(idx);
  assign raddr  = MEM_AW'(rd_slot) * MEM_AW'(MAX_N) + MEM_AW'(rd_idx);

  // Next-state and control decode
  always_comb begin
    state_d   = state;
    status_d  = status;
    latch_cmd = 1'b0;
    clr_valid = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (start_stp) begin
          latch_cmd = 1'b1;
          status_d  = 2'd0;
          state_d   = CHECK;
        end
      end
      CHECK: begin
        if (n_q == N_W'(0)) begin
          status_d = 2'd1;
          state_d  = DONE;
        end else if (n_q > N_W'(MAX_N)) begin
          status_d = 2'd2;
          state_d  = DONE;
        end else begin
          clr_valid = 1'b1;
          state_d   = GET;
        end
      end
      GET: begin
        if (beat_c && (idx == n_q - N_W'(1))) state_d = DONE;
      end
      DONE: begin
        commit  = (status == 2'd0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, control registers and read port
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      en_rd_data <= 1'b0;
      done_stp   <= 1'b0;
      status     <= 2'd0;
      slot_valid <= '0;
      idx        <= '0;
      a_q        <= '0;
      n_q        <= '0;
      rd_coeff   <= '0;
      rd_n       <= '0;
    end else begin
      state      <= state_d;
      en_rd_data <= (state_d == GET);
      done_stp   <= (state_d == DONE);
      status     <= status_d;
      if (latch_cmd) begin
        a_q <= A;
        n_q <= N;
      end
      if (clr_valid) begin
        idx             <= '0;
        slot_valid[a_q] <= 1'b0;
      end else if (beat_c) begin
        idx <= idx + N_W'(1);
      end
      if (commit) slot_valid[a_q] <= 1'b1;
      rd_n     <= slot_valid[rd_slot] ? len[rd_slot] : '0;
      rd_coeff <= (slot_valid[rd_slot] && (rd_idx < len[rd_slot])) ? mem[raddr] : '0;
    end
  end

  // Storage is never reset; slot_valid gates every read
  always_ff @(posedge clk) begin
    if (beat_c) mem[waddr] <= c;
    if (commit) len[a_q] <= n_q;
  end

endmodule

// File: tb/tb_stp_fsm_param.sv
// Directed bench for stp_fsm_param: stores, error commands, gapped beats,
// slot overwrite visibility and mid-store reset.
module tb_stp_fsm_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_stp;
  logic [2:0]  A;
  logic [4:0]  N;
  logic        en_mode_wr_coeff;
  logic [15:0] c;
  logic        en_rd_data;
  logic        done_stp;
  logic [1:0]  status;
  logic [7:0]  slot_valid;
  logic [2:0]  rd_slot;
  logic [4:0]  rd_idx;
  logic [15:0] rd_coeff;
  logic [4:0]  rd_n;

  int checks = 0;
  int failures = 0;

  stp_fsm_param dut (
    .clk(clk), .rst(rst), .start_stp(start_stp), .A(A), .N(N),
    .en_mode_wr_coeff(en_mode_wr_coeff), .c(c), .en_rd_data(en_rd_data),
    .done_stp(done_stp), .status(status), .slot_valid(slot_valid),
    .rd_slot(rd_slot), .rd_idx(rd_idx), .rd_coeff(rd_coeff), .rd_n(rd_n)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] s, input logic [4:0] i,
                        input logic [15:0] exp_c, input logic [4:0] exp_n);
    rd_slot = s;
    rd_idx  = i;
    tick();
    chk({tag, "_coeff"}, 32'(rd_coeff), 32'(exp_c));
    chk({tag, "_n"}, 32'(rd_n), 32'(exp_n));
  endtask

  logic [6:0] gap_pat;

  initial begin
    rst = 1'b0; start_stp = 1'b0; A = '0; N = '0;
    en_mode_wr_coeff = 1'b0; c = '0; rd_slot = '0; rd_idx = '0;
    tick(); tick();
    chk("rst_en_rd", 32'(en_rd_data), 32'd0);
    chk("rst_done", 32'(done_stp), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_valid", 32'(slot_valid), 32'd0);
    chk("rst_rd_coeff", 32'(rd_coeff), 32'd0);
    chk("rst_rd_n", 32'(rd_n), 32'd0);
    rst = 1'b1;
    tick();

    // 1: slot 2, three back-to-back beats
    start_stp = 1'b1; A = 3'd2; N = 5'd3;
    tick();
    start_stp = 1'b0;
    chk("t1_check_en_rd", 32'(en_rd_data), 32'd0);
    tick();
    chk("t1_get_en_rd", 32'(en_rd_data), 32'd1);
    en_mode_wr_coeff = 1'b1; c = 16'h0011; tick();
    c = 16'h0022; tick();
    chk("t1_mid_done", 32'(done_stp), 32'd0);
    c = 16'h0033; tick();
    en_mode_wr_coeff = 1'b0;
    chk("t1_done", 32'(done_stp), 32'd1);
    chk("t1_done_en_rd", 32'(en_rd_data), 32'd0);
    chk("t1_status", 32'(status), 32'd0);
    tick();
    chk("t1_done_clr", 32'(done_stp), 32'd0);
    chk("t1_valid", 32'(slot_valid), 32'h04);
    rd_chk("t1_rd0", 3'd2, 5'd0, 16'h0011, 5'd3);
    rd_chk("t1_rd1", 3'd2, 5'd1, 16'h0022, 5'd3);
    rd_chk("t1_rd2", 3'd2, 5'd2, 16'h0033, 5'd3);
    rd_chk("t1_rd3", 3'd2, 5'd3, 16'h0000, 5'd3);
    rd_chk("t1_rd_empty", 3'd1, 5'd0, 16'h0000, 5'd0);

    // 2: N=0 error
    start_stp = 1'b1; A = 3'd5; N = 5'd0;
    tick();
    start_stp = 1'b0;
    chk("t2_t1_done", 32'(done_stp), 32'd0);
    chk("t2_t1_en_rd", 32'(en_rd_data), 32'd0);
    tick();
    chk("t2_done", 32'(done_stp), 32'd1);
    chk("t2_status", 32'(status), 32'd1);
    chk("t2_en_rd", 32'(en_rd_data), 32'd0);
    tick();
    chk("t2_done_clr", 32'(done_stp), 32'd0);
    chk("t2_status_held", 32'(status), 32'd1);
    chk("t2_valid", 32'(slot_valid), 32'h04);

    // 3: N above MAX_N
    start_stp = 1'b1; A = 3'd1; N = 5'd17;
    tick();
    start_stp = 1'b0;
    chk("t3_status_clr", 32'(status), 32'd0);
    tick();
    chk("t3_done", 32'(done_stp), 32'd1);
    chk("t3_status", 32'(status), 32'd2);
    chk("t3_en_rd", 32'(en_rd_data), 32'd0);
    tick();
    chk("t3_valid", 32'(slot_valid), 32'h04);
    rd_chk("t3_rd_slot2", 3'd2, 5'd1, 16'h0022, 5'd3);

    // 4: slot 0, valid pattern 1,0,0,1,1,0,1 with data 0xA0+cycle
    start_stp = 1'b1; A = 3'd0; N = 5'd4;
    tick();
    start_stp = 1'b0;
    tick();
    gap_pat = 7'b1011001;
    for (int i = 0; i < 7; i++) begin
      en_mode_wr_coeff = gap_pat[i];
      c = 16'h00A0 + 16'(i);
      tick();
      if (i == 4) chk("t4_mid_done", 32'(done_stp), 32'd0);
    end
    en_mode_wr_coeff = 1'b0;
    chk("t4_done", 32'(done_stp), 32'd1);
    chk("t4_status", 32'(status), 32'd0);
    tick();
    chk("t4_valid", 32'(slot_valid), 32'h05);
    rd_chk("t4_rd0", 3'd0, 5'd0, 16'h00A0, 5'd4);
    rd_chk("t4_rd1", 3'd0, 5'd1, 16'h00A3, 5'd4);
    rd_chk("t4_rd2", 3'd0, 5'd2, 16'h00A4, 5'd4);
    rd_chk("t4_rd3", 3'd0, 5'd3, 16'h00A6, 5'd4);

    // 5: overwrite slot 2 with two beats; stray start mid-GET
    rd_slot = 3'd2; rd_idx = 5'd0;
    start_stp = 1'b1; A = 3'd2; N = 5'd2;
    tick();
    start_stp = 1'b0;
    tick();
    start_stp = 1'b1; A = 3'd6; N = 5'd9;
    en_mode_wr_coeff = 1'b1; c = 16'h0055;
    tick();
    start_stp = 1'b0;
    chk("t5_hidden_n", 32'(rd_n), 32'd0);
    chk("t5_hidden_coeff", 32'(rd_coeff), 32'd0);
    c = 16'h0066;
    tick();
    en_mode_wr_coeff = 1'b0;
    chk("t5_done", 32'(done_stp), 32'd1);
    chk("t5_done_rd_n", 32'(rd_n), 32'd0);
    chk("t5_done_valid", 32'(slot_valid), 32'h01);
    tick();
    chk("t5_valid", 32'(slot_valid), 32'h05);
    chk("t5_idle_en_rd", 32'(en_rd_data), 32'd0);
    rd_chk("t5_rd0", 3'd2, 5'd0, 16'h0055, 5'd2);
    rd_chk("t5_rd1", 3'd2, 5'd1, 16'h0066, 5'd2);
    rd_chk("t5_rd2", 3'd2, 5'd2, 16'h0000, 5'd2);

    // 6: reset mid-store, then a fresh store
    start_stp = 1'b1; A = 3'd3; N = 5'd5;
    tick();
    start_stp = 1'b0;
    tick();
    en_mode_wr_coeff = 1'b1; c = 16'h0077; tick();
    c = 16'h0088; tick();
    rst = 1'b0; en_mode_wr_coeff = 1'b0;
    tick();
    chk("t6_rst_en_rd", 32'(en_rd_data), 32'd0);
    chk("t6_rst_done", 32'(done_stp), 32'd0);
    chk("t6_rst_status", 32'(status), 32'd0);
    chk("t6_rst_valid", 32'(slot_valid), 32'd0);
    chk("t6_rst_rd_coeff", 32'(rd_coeff), 32'd0);
    chk("t6_rst_rd_n", 32'(rd_n), 32'd0);
    rst = 1'b1;
    tick();
    chk("t6_no_done", 32'(done_stp), 32'd0);
    start_stp = 1'b1; A = 3'd3; N = 5'd1;
    tick();
    start_stp = 1'b0;
    tick();
    chk("t6_get", 32'(en_rd_data), 32'd1);
    en_mode_wr_coeff = 1'b1; c = 16'h0099;
    tick();
    en_mode_wr_coeff = 1'b0;
    chk("t6_done", 32'(done_stp), 32'd1);
    tick();
    chk("t6_valid", 32'(slot_valid), 32'h08);
    rd_chk("t6_rd0", 3'd3, 5'd0, 16'h0099, 5'd1);
    rd_chk("t6_rd_old_slot2", 3'd2, 5'd0, 16'h0000, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
